// File: rtl/video_timing_pattern_gen.sv
// Raster timing and test-pattern source feeding tmds_tx.
// Produces hsync/vsync/de and 24-bit RGB test patterns in the pixel clock domain.
// Timing is parameterised; the defaults give CEA 1280x720p60.
//
// Ports:
//   clk          pixel clock
//   rst          synchronous reset, active-high
//   pattern      pattern select: 00 bars, 01 ramp, 10 checker, 11 grey
//                (latched at frame boundary and during reset)
//   hsync/vsync  syncs, active level HS_POL / VS_POL
//   de           data enable, high in the active area
//   red/green/blue  pixel colour, zero outside the active area
//   hcount/vcount   coordinates of the pixel currently on the outputs
//   frame_start  one-clock pulse with pixel (0,0)
// All outputs are registered and mutually aligned, one clock behind the counters.
module video_timing_pattern_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pattern,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic [11:0] hcount,
  output logic [11:0] vcount,
  output logic        frame_start
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;
  localparam int BAR_W    = H_ACTIVE / 8;

  typedef enum logic [1:0] {
    PAT_BARS    = 2'b00,
    PAT_RAMP    = 2'b01,
    PAT_CHECKER = 2'b10,
    PAT_GREY    = 2'b11
  } pattern_e;

  logic [11:0] h, v;
  logic [11:0] bar_pos;
  logic [2:0]  bar_idx;
  pattern_e    pat_q;

  logic        h_end, v_end;
  logic        active, hs_act, vs_act;
  logic [23:0] rgb_n;

  assign h_end = (h == 12'(H_TOTAL - 1));
  assign v_end = (v == 12'(V_TOTAL - 1));

  always_comb begin
    active = (h < 12'(H_ACTIVE)) && (v < 12'(V_ACTIVE));
    hs_act = (h >= 12'(HS_START)) && (h < 12'(HS_END));
    // v only changes on the h wrap, so vsync edges land on h=0
    vs_act = (v >= 12'(VS_START)) && (v < 12'(VS_END));
    rgb_n  = '0;
    if (active) begin
      unique case (pat_q)
        PAT_BARS: begin
          unique case (bar_idx)
            3'd0: rgb_n = 24'hFFFFFF;
            3'd1: rgb_n = 24'hFFFF00;
            3'd2: rgb_n = 24'h00FFFF;
            3'd3: rgb_n = 24'h00FF00;
            3'd4: rgb_n = 24'hFF00FF;
            3'd5: rgb_n = 24'hFF0000;
            3'd6: rgb_n = 24'h0000FF;
            default: rgb_n = 24'h000000;
          endcase
        end
        PAT_RAMP:    rgb_n = {3{h[7:0]}};
        PAT_CHECKER: rgb_n = (h[5] ^ v[5]) ? 24'hFFFFFF : 24'h000000;
        default:     rgb_n = 24'h808080;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h           <= '0;
      v           <= '0;
      bar_pos     <= '0;
      bar_idx     <= '0;
      pat_q       <= pattern_e'(pattern);
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      hcount      <= '0;
      vcount      <= '0;
      frame_start <= 1'b0;
    end else begin
      // raster counters
      if (h_end) begin
        h <= '0;
        v <= v_end ? '0 : v + 12'd1;
      end else begin
        h <= h + 12'd1;
      end

      // bar index tracks h by counting bar widths, avoiding a divider;
      // past the active area it wraps harmlessly since de masks the colour
      if (h_end) begin
        bar_pos <= '0;
        bar_idx <= '0;
      end else if (bar_pos == 12'(BAR_W - 1)) begin
        bar_pos <= '0;
        bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_pos <= bar_pos + 12'd1;
      end

      if (h_end && v_end)
        pat_q <= pattern_e'(pattern);

      hsync       <= hs_act ? HS_POL : ~HS_POL;
      vsync       <= vs_act ? VS_POL : ~VS_POL;
      de          <= active;
      red         <= rgb_n[23:16];
      green       <= rgb_n[15:8];
      blue        <= rgb_n[7:0];
      hcount      <= h;
      vcount      <= v;
      frame_start <= (h == '0) && (v == '0);
    end
  end

endmodule

// File: tb/tb_video_timing_pattern_gen.sv
// Directed bench for video_timing_pattern_gen using a reduced raster so whole
// frames fit in a short run: 64 active + 4 fp + 6 sync + 6 bp = 80 clocks/line,
// 40 active + 2 fp + 3 sync + 3 bp = 48 lines/frame, bar width 8.
module tb_video_timing_pattern_gen;

  localparam int HA = 64, HFP = 4, HS = 6, HBP = 6;
  localparam int VA = 40, VFP = 2, VS = 3, VBP = 3;
  localparam int HT = HA + HFP + HS + HBP;   // 80
  localparam int VT = VA + VFP + VS + VBP;   // 48
  localparam int WAIT_LIMIT = 2 * HT * VT + 100;

  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  pattern = 2'b00;
  logic        hsync, vsync, de, frame_start;
  logic [7:0]  red, green, blue;
  logic [11:0] hcount, vcount;

  int errors = 0;
  int checks = 0;

  video_timing_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .pattern(pattern),
    .hsync(hsync), .vsync(vsync), .de(de),
    .red(red), .green(green), .blue(blue),
    .hcount(hcount), .vcount(vcount), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Positions the bench on a given output pixel; a timeout is a failed check.
  task automatic wait_for(input int hx, input int vy);
    int n;
    n = 0;
    while (!(hcount == 12'(hx) && vcount == 12'(vy)) && n < WAIT_LIMIT) begin
      tick();
      n++;
    end
    if (n >= WAIT_LIMIT) begin
      checks++; errors++;
      $display("FAIL wait_for(%0d,%0d): timed out at hcount=%0d vcount=%0d", hx, vy, hcount, vcount);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pattern = 2'b00;
    repeat (3) tick();
    checks++; if (de !== 1'b0) begin errors++; $display("FAIL reset_de: got %b want 0", de); end
    checks++; if (hsync !== 1'b0) begin errors++; $display("FAIL reset_hsync: got %b want 0", hsync); end
    checks++; if (vsync !== 1'b0) begin errors++; $display("FAIL reset_vsync: got %b want 0", vsync); end
    checks++; if ({red, green, blue} !== 24'h000000) begin errors++; $display("FAIL reset_rgb: got %h want 000000", {red, green, blue}); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs: got %b want 0", frame_start); end
    checks++; if (hcount !== 12'd0 || vcount !== 12'd0) begin errors++; $display("FAIL reset_count: got %0d,%0d want 0,0", hcount, vcount); end
    rst = 1'b0;
    tick();
    checks++; if (de !== 1'b1) begin errors++; $display("FAIL first_de: got %b want 1", de); end
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL first_fs: got %b want 1", frame_start); end
    checks++; if (hcount !== 12'd0 || vcount !== 12'd0) begin errors++; $display("FAIL first_count: got %0d,%0d want 0,0", hcount, vcount); end
    checks++; if ({red, green, blue} !== 24'hFFFFFF) begin errors++; $display("FAIL first_rgb: got %h want FFFFFF", {red, green, blue}); end
  endtask

  // Starts on output pixel (0,0), records two lines, ends on (0,2).
  task automatic test_line_timing();
    logic        de_a [2*HT];
    logic        hs_a [2*HT];
    logic [23:0] rgb_a [2*HT];
    logic [11:0] hc_a [2*HT];
    int de_cnt, de_fall, hs_rise, hs_fall, hs_rise2;
    for (int c = 0; c < 2*HT; c++) begin
      de_a[c] = de; hs_a[c] = hsync; rgb_a[c] = {red, green, blue}; hc_a[c] = hcount;
      tick();
    end
    de_cnt = 0; de_fall = -1; hs_rise = -1; hs_fall = -1; hs_rise2 = -1;
    for (int c = 0; c < HT; c++) if (de_a[c]) de_cnt++;
    for (int c = 1; c < 2*HT; c++) begin
      if (de_fall < 0 && de_a[c-1] && !de_a[c]) de_fall = c;
      if (!hs_a[c-1] && hs_a[c]) begin
        if (hs_rise < 0) hs_rise = c;
        else if (hs_rise2 < 0) hs_rise2 = c;
      end
      if (hs_fall < 0 && hs_a[c-1] && !hs_a[c]) hs_fall = c;
    end
    checks++; if (de_cnt != 64) begin errors++; $display("FAIL de_per_line: got %0d want 64", de_cnt); end
    checks++; if (de_fall != 64) begin errors++; $display("FAIL de_fall: got %0d want 64", de_fall); end
    checks++; if (hs_rise - de_fall != 4) begin errors++; $display("FAIL hs_after_de: got %0d want 4", hs_rise - de_fall); end
    checks++; if (hs_fall - hs_rise != 6) begin errors++; $display("FAIL hs_width: got %0d want 6", hs_fall - hs_rise); end
    checks++; if (hs_rise2 - hs_rise != 80) begin errors++; $display("FAIL hs_period: got %0d want 80", hs_rise2 - hs_rise); end
    checks++; if (hc_a[7] !== 12'd7) begin errors++; $display("FAIL hcount_track: got %0d want 7", hc_a[7]); end
    checks++; if (rgb_a[7] !== 24'hFFFFFF) begin errors++; $display("FAIL bar_last0: got %h want FFFFFF", rgb_a[7]); end
    checks++; if (rgb_a[8] !== 24'hFFFF00) begin errors++; $display("FAIL bar_first1: got %h want FFFF00", rgb_a[8]); end
    checks++; if (rgb_a[63] !== 24'h000000) begin errors++; $display("FAIL bar_last7: got %h want 000000", rgb_a[63]); end
    checks++; if (rgb_a[64] !== 24'h000000 || de_a[64] !== 1'b0) begin errors++; $display("FAIL blank_rgb: got %h de=%b want 000000 de=0", rgb_a[64], de_a[64]); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rgb_a[HT + 8*i + 3] !== BARS[i]) begin
        errors++; $display("FAIL bar%0d: got %h want %h", i, rgb_a[HT + 8*i + 3], BARS[i]);
      end
    end
  endtask

  // Starts on output (0,2) and walks one whole frame of clocks.
  task automatic test_frame_timing();
    int vs_cnt, vs_rise, fs_cnt, fs_at, de_cnt, de_blank, line;
    logic vs_prev;
    logic [11:0] rise_h, rise_v;
    vs_cnt = 0; vs_rise = -1; fs_cnt = 0; fs_at = -1; de_cnt = 0; de_blank = 0;
    rise_h = '1; rise_v = '1;
    vs_prev = vsync;
    for (int c = 0; c < HT*VT; c++) begin
      line = ((c / HT) + 2) % VT;
      if (vsync) vs_cnt++;
      if (vsync && !vs_prev && vs_rise < 0) begin vs_rise = c; rise_h = hcount; rise_v = vcount; end
      if (frame_start) begin fs_cnt++; if (fs_at < 0) fs_at = c; end
      if (de) de_cnt++;
      if (de && line >= VA) de_blank++;
      vs_prev = vsync;
      tick();
    end
    checks++; if (vs_cnt != 240) begin errors++; $display("FAIL vs_width: got %0d want 240", vs_cnt); end
    checks++; if (vs_rise != 3200) begin errors++; $display("FAIL vs_rise: got %0d want 3200", vs_rise); end
    checks++; if (rise_h !== 12'd0 || rise_v !== 12'd42) begin errors++; $display("FAIL vs_align: got %0d,%0d want 0,42", rise_h, rise_v); end
    checks++; if (fs_cnt != 1 || fs_at != 3680) begin errors++; $display("FAIL fs_period: got count=%0d at=%0d want 1 at 3680", fs_cnt, fs_at); end
    checks++; if (de_cnt != 2560) begin errors++; $display("FAIL de_per_frame: got %0d want 2560", de_cnt); end
    checks++; if (de_blank != 0) begin errors++; $display("FAIL de_vblank: got %0d want 0", de_blank); end
  endtask

  task automatic test_pattern_switch();
    wait_for(20, 10);
    pattern = 2'b10;
    wait_for(24, 10);
    checks++; if ({red, green, blue} !== 24'h00FF00) begin errors++; $display("FAIL sw_bars_now: got %h want 00FF00", {red, green, blue}); end
    wait_for(24, 39);
    checks++; if ({red, green, blue} !== 24'h00FF00) begin errors++; $display("FAIL sw_bars_last: got %h want 00FF00", {red, green, blue}); end
    wait_for(0, 0);
    checks++; if ({red, green, blue} !== 24'h000000 || frame_start !== 1'b1) begin errors++; $display("FAIL chk_00: got %h fs=%b want 000000 fs=1", {red, green, blue}, frame_start); end
    wait_for(32, 0);
    checks++; if ({red, green, blue} !== 24'hFFFFFF) begin errors++; $display("FAIL chk_32_0: got %h want FFFFFF", {red, green, blue}); end
    wait_for(0, 32);
    checks++; if ({red, green, blue} !== 24'hFFFFFF) begin errors++; $display("FAIL chk_0_32: got %h want FFFFFF", {red, green, blue}); end
    wait_for(32, 32);
    checks++; if ({red, green, blue} !== 24'h000000) begin errors++; $display("FAIL chk_32_32: got %h want 000000", {red, green, blue}); end
    wait_for(70, 32);
    checks++; if ({red, green, blue} !== 24'h000000 || de !== 1'b0) begin errors++; $display("FAIL chk_blank: got %h de=%b want 000000 de=0", {red, green, blue}, de); end
  endtask

  task automatic test_ramp();
    pattern = 2'b01;
    wait_for(5, 35);
    checks++; if ({red, green, blue} !== 24'hFFFFFF) begin errors++; $display("FAIL ramp_held: got %h want FFFFFF", {red, green, blue}); end
    wait_for(0, 0);
    checks++; if ({red, green, blue} !== 24'h000000) begin errors++; $display("FAIL ramp_0: got %h want 000000", {red, green, blue}); end
    wait_for(37, 5);
    checks++; if ({red, green, blue} !== 24'h252525) begin errors++; $display("FAIL ramp_37: got %h want 252525", {red, green, blue}); end
    wait_for(63, 39);
    checks++; if ({red, green, blue} !== 24'h3F3F3F) begin errors++; $display("FAIL ramp_63: got %h want 3F3F3F", {red, green, blue}); end
  endtask

  task automatic test_grey();
    pattern = 2'b11;
    wait_for(0, 0);
    checks++; if ({red, green, blue} !== 24'h808080) begin errors++; $display("FAIL grey_0: got %h want 808080", {red, green, blue}); end
    wait_for(10, 3);
    checks++; if ({red, green, blue} !== 24'h808080) begin errors++; $display("FAIL grey_10_3: got %h want 808080", {red, green, blue}); end
    wait_for(64, 39);
    checks++; if ({red, green, blue} !== 24'h000000 || de !== 1'b0) begin errors++; $display("FAIL grey_blank: got %h de=%b want 000000 de=0", {red, green, blue}, de); end
  endtask

  task automatic test_mid_reset();
    wait_for(45, 25);
    rst = 1'b1;
    tick();
    checks++; if (de !== 1'b0 || frame_start !== 1'b0) begin errors++; $display("FAIL mr_de_fs: got de=%b fs=%b want 0 0", de, frame_start); end
    checks++; if (hcount !== 12'd0 || vcount !== 12'd0) begin errors++; $display("FAIL mr_count: got %0d,%0d want 0,0", hcount, vcount); end
    checks++; if ({red, green, blue} !== 24'h000000 || hsync !== 1'b0 || vsync !== 1'b0) begin errors++; $display("FAIL mr_outs: got rgb=%h hs=%b vs=%b want 000000 0 0", {red, green, blue}, hsync, vsync); end
    rst = 1'b0;
    tick();
    checks++; if (frame_start !== 1'b1 || de !== 1'b1) begin errors++; $display("FAIL mr_restart: got fs=%b de=%b want 1 1", frame_start, de); end
    checks++; if (hcount !== 12'd0 || vcount !== 12'd0) begin errors++; $display("FAIL mr_origin: got %0d,%0d want 0,0", hcount, vcount); end
    checks++; if ({red, green, blue} !== 24'h808080) begin errors++; $display("FAIL mr_rgb: got %h want 808080", {red, green, blue}); end
    tick();
    checks++; if (hcount !== 12'd1 || frame_start !== 1'b0) begin errors++; $display("FAIL mr_next: got h=%0d fs=%b want 1 0", hcount, frame_start); end
  endtask

  initial begin
    test_reset();
    test_line_timing();
    test_frame_timing();
    test_pattern_switch();
    test_ramp();
    test_grey();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/video_timing_pattern_gen.md
Name: video_timing_pattern_gen

Overview:
Upstream source stage for tmds_tx. Generates raster timing (hsync, vsync, de) plus 24-bit test-pattern pixels in the pixel clock domain, and feeds tmds_tx's hsync/vsync/de/red/green/blue inputs directly. Timing is parameterised; defaults are CEA 1280x720p60. All outputs are registered.

Parameters:
H_ACTIVE, 1280, active pixels per line (must be divisible by 8)
H_FP, 110, horizontal front porch, clocks
H_SYNC, 40, hsync width, clocks
H_BP, 220, horizontal back porch, clocks
V_ACTIVE, 720, active lines per frame
V_FP, 5, vertical front porch, lines
V_SYNC, 5, vsync width, lines
V_BP, 20, vertical back porch, lines
HS_POL, 1, hsync active level
VS_POL, 1, vsync active level

Ports:
clk  input  1  pixel clock
rst  input  1  synchronous reset, active-high
pattern  input  2  pattern select: 00 bars, 01 ramp, 10 checker, 11 grey
hsync  output  1  horizontal sync, polarity HS_POL
vsync  output  1  vertical sync, polarity VS_POL
de  output  1  data enable, high in active area
red  output  8  red pixel
green  output  8  green pixel
blue  output  8  blue pixel
hcount  output  12  x coordinate of the current output pixel
vcount  output  12  y coordinate of the current output pixel
frame_start  output  1  one-clock pulse coincident with pixel (0,0)

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1650). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 750).
- Internal h counter runs 0..H_TOTAL-1 and wraps to 0. v counter increments on h wrap and runs 0..V_TOTAL-1, wrapping to 0 when h and v both wrap.
- Active area: h<H_ACTIVE and v<V_ACTIVE.
- hsync is active for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
- vsync is active for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC. vsync transitions are aligned to h=0.
- Latency: every output registers the current counter state, so outputs lag the counters by one clock. All outputs, including hcount/vcount, are mutually aligned.
- Reset: rst high at an edge sets h=v=0, de=0, frame_start=0, hsync=~HS_POL, vsync=~VS_POL, colours=0, hcount=vcount=0, and loads the pattern latch from the pattern input.
- On the first edge with rst low, the outputs present pixel (0,0): de=1, frame_start=1.
- Reset asserted mid-frame takes effect at the next edge and restarts the raster at (0,0).
- Pattern latch: loaded when h=H_TOTAL-1 and v=V_TOTAL-1, and during reset. Pattern changes therefore take effect only at a frame boundary, with no mid-frame tearing.
- frame_start is high only at the output clock where hcount=0, vcount=0 and de=1.
- When de=0, red/green/blue are 0.
- Pattern 00, colour bars:
  - 8 bars, each BAR_W=H_ACTIVE/8 wide (160 by default).
  - Bar order, RGB: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - Bar index comes from a bar counter plus an in-bar counter reset at h=0. No divider.
- Pattern 01, ramp: red=green=blue=h[7:0].
- Pattern 10, checker: 32x32 squares; value = FF if h[5]^v[5], else 00, on all three channels.
- Pattern 11, solid grey: 808080.
- Counter widths are 12 bits. Parameters must satisfy H_TOTAL and V_TOTAL <= 4096.

Test Plan:
- Reset: hold rst 3 clocks with pattern=00 -> de=0, hsync=0, vsync=0, RGB=000000. On the first edge after release: de=1, frame_start=1, hcount=0, vcount=0, RGB=FFFFFF.
- Line timing, defaults:
  - de high for 1280 clocks per line.
  - hsync rises 110 clocks after de falls and stays high 40 clocks.
  - hsync period is 1650 clocks.
- Frame timing:
  - vsync high for 5 lines (8250 clocks), rising at the h=0 of line 725.
  - frame_start period is 1237500 clocks.
  - de is never high on lines 720..749.
- Colour bars: RGB=FFFFFF at hcount=159, FFFF00 at hcount=160, 000000 at hcount=1279. RGB=0 at hcount=1280.
- Pattern switch: change pattern 00->10 at (hcount=500, vcount=300) -> bars continue through the end of the frame. Next frame: (0,0)=000000, (32,0)=FFFFFF, (32,32)=000000.
- Mid-frame reset: assert rst for 1 clock at (700,400) -> next edge shows reset values. Following edge shows frame_start=1 at (0,0).
